hamming_best_tracker: RTL and testbench

Pipelined Hamming-distance scorer and best-candidate tracker that sits directly downstream of the Skein-1024 target-XOR stage. Each cycle it accepts one 1024-bit XOR result, the difference between a candidate hash and the target hash, together with the nonce/tag of the candidate that produced it. It popcounts the result to get the distance to the target and emits the distance per candidate. It also keeps the lowest distance seen so far, and its nonce, for the host readout logic.

---
 rtl/hamming_best_tracker.sv | 140 ++++++++++++++
 tb/tb_hamming_best_tracker.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_best_tracker.sv
// Pipelined 1024-bit Hamming-distance scorer with a lowest-distance (best candidate) record.
// Input capture, slice popcount, group sum and final sum stages; best record updates one cycle after the final sum.
module hamming_best_tracker #(
  parameter int NONCE_W = 64
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               valid_i,
  input  logic [1023:0]      hash_xor_i,
  input  logic [NONCE_W-1:0] nonce_i,
  input  logic               clear_i,
  output logic [10:0]        dist_o,
  output logic [NONCE_W-1:0] dist_nonce_o,
  output logic               dist_valid_o,
  output logic               best_valid_o,
  output logic [10:0]        best_dist_o,
  output logic [NONCE_W-1:0] best_nonce_o,
  output logic               best_update_o,
  output logic               busy_o
);

  localparam int SLICE_W = 16;
  localparam int N_SLICE = 64;
  localparam int CNT_W   = 5;
  localparam int GRP_SZ  = 8;
  localparam int N_GRP   = 8;
  localparam int PSUM_W  = 8;
  localparam logic [10:0] DIST_MAX = 11'd1024;

  function automatic logic [CNT_W-1:0] popcount16(input logic [SLICE_W-1:0] v);
    logic [CNT_W-1:0] c;
    c = '0;
    for (int i = 0; i < SLICE_W; i++) c = c + {{(CNT_W-1){1'b0}}, v[i]};
    return c;
  endfunction

  function automatic logic [PSUM_W-1:0] group_sum(input logic [GRP_SZ*CNT_W-1:0] g);
    logic [PSUM_W-1:0] acc;
    acc = '0;
    for (int k = 0; k < GRP_SZ; k++)
      acc = acc + {{(PSUM_W-CNT_W){1'b0}}, g[k*CNT_W +: CNT_W]};
    return acc;
  endfunction

  function automatic logic [10:0] total_sum(input logic [N_GRP*PSUM_W-1:0] p);
    logic [10:0] acc;
    acc = '0;
    for (int g = 0; g < N_GRP; g++)
      acc = acc + {{(11-PSUM_W){1'b0}}, p[g*PSUM_W +: PSUM_W]};
    return acc;
  endfunction

  logic                      vld_p0, vld_p1, vld_p2, vld_p3;
  logic [1023:0]             hash_p0;
  logic [NONCE_W-1:0]        nonce_p0, nonce_p1, nonce_p2;
  logic [N_SLICE*CNT_W-1:0]  cnt_d, cnt_p1;
  logic [N_GRP*PSUM_W-1:0]   psum_d, psum_p2;
  logic [10:0]               dist_d;
  logic                      take_best;

  always_comb begin
    cnt_d = '0;
    for (int s = 0; s < N_SLICE; s++)
      cnt_d[s*CNT_W +: CNT_W] = popcount16(hash_p0[s*SLICE_W +: SLICE_W]);
  end

  always_comb begin
    psum_d = '0;
    for (int g = 0; g < N_GRP; g++)
      psum_d[g*PSUM_W +: PSUM_W] = group_sum(cnt_p1[g*GRP_SZ*CNT_W +: GRP_SZ*CNT_W]);
  end

  assign dist_d = total_sum(psum_p2);

  // Valid chain and output stage; data registers below hold while their stage is empty.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      vld_p3       <= 1'b0;
      dist_o       <= '0;
      dist_nonce_o <= '0;
    end else begin
      vld_p0 <= valid_i;
      vld_p1 <= vld_p0;
      vld_p2 <= vld_p1;
      vld_p3 <= vld_p2;
      if (vld_p2) begin
        dist_o       <= dist_d;
        dist_nonce_o <= nonce_p2;
      end
    end
  end

  // Stage p0: capture; stage p1: slice popcounts; stage p2: group partial sums.
  always_ff @(posedge clk_i) begin
    if (valid_i) begin
      hash_p0  <= hash_xor_i;
      nonce_p0 <= nonce_i;
    end
    if (vld_p0) begin
      cnt_p1   <= cnt_d;
      nonce_p1 <= nonce_p0;
    end
    if (vld_p1) begin
      psum_p2  <= psum_d;
      nonce_p2 <= nonce_p1;
    end
  end

  assign dist_valid_o = vld_p3;
  assign busy_o       = vld_p1 | vld_p2 | vld_p3;

  // Strict less-than keeps the earlier candidate on ties; an empty record accepts anything.
  assign take_best = dist_valid_o && (!best_valid_o || (dist_o < best_dist_o));

  // Best-record stage: clear wins over a simultaneous update.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      best_valid_o  <= 1'b0;
      best_dist_o   <= DIST_MAX;
      best_nonce_o  <= '0;
      best_update_o <= 1'b0;
    end else if (clear_i) begin
      best_valid_o  <= 1'b0;
      best_dist_o   <= DIST_MAX;
      best_nonce_o  <= '0;
      best_update_o <= 1'b0;
    end else if (take_best) begin
      best_valid_o  <= 1'b1;
      best_dist_o   <= dist_o;
      best_nonce_o  <= dist_nonce_o;
      best_update_o <= 1'b1;
    end else begin
      best_update_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_hamming_best_tracker.sv
// Scoreboard bench for hamming_best_tracker: driver pushes expected distances, a negedge monitor
// checks timing, data, busy and the best record against a min-over-history reference.
module tb_hamming_best_tracker;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          valid_i;
  logic [1023:0] hash_xor_i;
  logic [63:0]   nonce_i;
  logic          clear_i;
  logic [10:0]   dist_o;
  logic [63:0]   dist_nonce_o;
  logic          dist_valid_o;
  logic          best_valid_o;
  logic [10:0]   best_dist_o;
  logic [63:0]   best_nonce_o;
  logic          best_update_o;
  logic          busy_o;

  hamming_best_tracker #(.NONCE_W(64)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .valid_i(valid_i), .hash_xor_i(hash_xor_i),
    .nonce_i(nonce_i), .clear_i(clear_i), .dist_o(dist_o), .dist_nonce_o(dist_nonce_o),
    .dist_valid_o(dist_valid_o), .best_valid_o(best_valid_o), .best_dist_o(best_dist_o),
    .best_nonce_o(best_nonce_o), .best_update_o(best_update_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned edge_n;
    logic [10:0] d;
    logic [63:0] n;
  } item_t;

  item_t       sbq[$];
  logic [10:0] rec_d[$];
  logic [63:0] rec_n[$];
  int unsigned edge_cnt = 0;
  int          errors = 0;
  int          checks = 0;
  int          upd_seen = 0;
  logic        exp_bv, exp_upd;
  logic [10:0] exp_bd;
  logic [63:0] exp_bn;

  always @(posedge clk) edge_cnt++;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    sbq.delete();
    rec_d.delete();
    rec_n.delete();
    exp_bv  = 1'b0;
    exp_bd  = 11'd1024;
    exp_bn  = '0;
    exp_upd = 1'b0;
  endtask

  function automatic logic [1023:0] rand_vec();
    logic [1023:0] v;
    for (int w = 0; w < 32; w++) v[w*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [1023:0] rand_hash();
    int unsigned m;
    m = $urandom_range(0, 9);
    case (m)
      0: return '0;
      1: return '1;
      2, 3: return rand_vec() & rand_vec() & rand_vec();
      4, 5: return rand_vec() | rand_vec();
      default: return rand_vec();
    endcase
  endfunction

  function automatic logic [1023:0] dist_hash(input int d);
    logic [1023:0] v;
    int r;
    v = '0;
    for (int i = 0; i < d; i++) v[i] = 1'b1;
    r = $urandom_range(0, 1023);
    if (r != 0) v = (v << r) | (v >> (1024 - r));
    return v;
  endfunction

  task automatic send(input logic [1023:0] h, input logic [63:0] n, input logic clr);
    item_t it;
    @(posedge clk);
    #1;
    valid_i    = 1'b1;
    hash_xor_i = h;
    nonce_i    = n;
    clear_i    = clr;
    it.edge_n  = edge_cnt + 1;
    it.d       = 11'($countones(h));
    it.n       = n;
    sbq.push_back(it);
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      #1;
      valid_i    = 1'b0;
      hash_xor_i = rand_vec();
      nonce_i    = {$urandom, $urandom};
      clear_i    = 1'b0;
    end
  endtask

  task automatic clear_slot();
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    clear_i = 1'b1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_dist_valid"}, dist_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_best_valid"}, best_valid_o, 0);
    chk({tag, "_best_dist"}, best_dist_o, 11'd1024);
    chk({tag, "_best_nonce"}, best_nonce_o, 0);
    chk({tag, "_best_update"}, best_update_o, 0);
  endtask

  // Monitor: the reference best is the earliest minimum over all candidates recorded since clear/reset.
  always @(negedge clk) begin
    if (rst_n) begin
      logic busy_e, dv_e;
      int   bi;
      item_t it;
      if (best_update_o) upd_seen++;
      chk("best_valid", best_valid_o, exp_bv);
      chk("best_dist", best_dist_o, exp_bd);
      chk("best_nonce", best_nonce_o, exp_bn);
      chk("best_update", best_update_o, exp_upd);
      busy_e = 1'b0;
      foreach (sbq[i])
        if ((edge_cnt - sbq[i].edge_n) >= 1 && (edge_cnt - sbq[i].edge_n) <= 3) busy_e = 1'b1;
      dv_e = (sbq.size() > 0) && (edge_cnt - sbq[0].edge_n == 3);
      chk("busy", busy_o, busy_e);
      chk("dist_valid", dist_valid_o, dv_e);
      exp_upd = 1'b0;
      if (dv_e) begin
        it = sbq.pop_front();
        chk("dist", dist_o, it.d);
        chk("dist_nonce", dist_nonce_o, it.n);
      end
      if (clear_i) begin
        rec_d.delete();
        rec_n.delete();
      end else if (dv_e) begin
        rec_d.push_back(it.d);
        rec_n.push_back(it.n);
      end
      bi = -1;
      foreach (rec_d[i]) if (bi < 0 || rec_d[i] < rec_d[bi]) bi = i;
      exp_bv = (bi >= 0);
      exp_bd = (bi >= 0) ? rec_d[bi] : 11'd1024;
      exp_bn = (bi >= 0) ? rec_n[bi] : 64'd0;
      if (!clear_i && dv_e) exp_upd = (bi == rec_d.size() - 1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    int u0;
    rst_n      = 1'b0;
    valid_i    = 1'b0;
    clear_i    = 1'b0;
    hash_xor_i = '0;
    nonce_i    = '0;
    model_reset();

    // Reset held with inputs toggling
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      valid_i    = 1'($urandom);
      clear_i    = 1'($urandom);
      hash_xor_i = rand_vec();
      nonce_i    = {$urandom, $urandom};
      #2;
      chk_reset_outputs("reset");
    end
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    clear_i = 1'b0;
    #1 rst_n = 1'b1;
    idle(2);

    // Single zero-distance candidate
    send('0, 64'hA, 1'b0);
    idle(6);
    chk("zero_best_dist", best_dist_o, 0);
    chk("zero_best_nonce", best_nonce_o, 64'hA);
    chk("zero_best_valid", best_valid_o, 1);
    chk("zero_update_count", upd_seen, 1);

    // Back-to-back stream 500/400/400/450
    clear_slot();
    idle(1);
    u0 = upd_seen;
    send(dist_hash(500), 64'd1, 1'b0);
    send(dist_hash(400), 64'd2, 1'b0);
    send(dist_hash(400), 64'd3, 1'b0);
    send(dist_hash(450), 64'd4, 1'b0);
    idle(7);
    chk("b2b_update_count", upd_seen - u0, 2);
    chk("b2b_best_dist", best_dist_o, 400);
    chk("b2b_best_nonce", best_nonce_o, 2);

    // First candidate is the worst possible
    clear_slot();
    idle(1);
    send('1, 64'h55, 1'b0);
    idle(6);
    chk("worst_best_valid", best_valid_o, 1);
    chk("worst_best_dist", best_dist_o, 11'd1024);
    chk("worst_best_nonce", best_nonce_o, 64'h55);
    u0 = upd_seen;
    send('1, 64'h66, 1'b0);
    idle(6);
    chk("worst_tie_no_update", upd_seen - u0, 0);
    chk("worst_tie_nonce", best_nonce_o, 64'h55);

    // Clear colliding with a result in the output stage
    clear_slot();
    idle(1);
    send(dist_hash(10), 64'h10, 1'b0);
    idle(6);
    chk("coll_pre_best", best_dist_o, 10);
    u0 = upd_seen;
    send(dist_hash(20), 64'h20, 1'b0);
    send(dist_hash(30), 64'h30, 1'b0);
    idle(2);
    clear_slot();
    idle(6);
    chk("coll_best_valid", best_valid_o, 1);
    chk("coll_best_dist", best_dist_o, 30);
    chk("coll_best_nonce", best_nonce_o, 64'h30);
    chk("coll_update_count", upd_seen - u0, 1);

    // Randomized stream with occasional clears
    for (int i = 0; i < 400; i++) begin
      int unsigned r;
      r = $urandom_range(0, 19);
      if (r < 12) send(rand_hash(), {$urandom, $urandom}, (r == 0));
      else if (r == 12) clear_slot();
      else idle(1);
    end
    idle(6);

    // Asynchronous reset with candidates in flight
    send(dist_hash(100), 64'h101, 1'b0);
    send(dist_hash(200), 64'h102, 1'b0);
    send(dist_hash(300), 64'h103, 1'b0);
    idle(1);
    @(posedge clk);
    #1;
    valid_i = 1'b0;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_outputs("midrst");
    chk("midrst_dist", dist_o, 0);
    chk("midrst_dist_nonce", dist_nonce_o, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    idle(8);

    for (int i = 0; i < 40; i++) send(rand_hash(), {$urandom, $urandom}, 1'b0);
    idle(8);
    chk("scoreboard_drained", sbq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
